// File: rtl/dvi_timing_pkg.sv
// DVI timing constants: default 640x480@60 geometry,
// derived totals, active-window bounds and datapath widths.
package dvi_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_SER      = 5;

  localparam int H_TOTAL =
    DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL =
    DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int H_ACT_START = DEF_H_SYNC + DEF_H_BP;
  localparam int H_ACT_END   = H_ACT_START + DEF_H_ACTIVE;
  localparam int V_ACT_START = DEF_V_SYNC + DEF_V_BP;
  localparam int V_ACT_END   = V_ACT_START + DEF_V_ACTIVE;

  localparam int PIX_W   = 24;
  localparam int COORD_W = 11;

endpackage

// File: rtl/video_axis_counter.sv
// Wrapping axis counter (h or v). Ports: clk, rst_n, inc;
// out: sync, active, pos (registered), wrap, nxt_act.
module video_axis_counter
  import dvi_timing_pkg::*;
#(
  parameter int TOTAL     = H_TOTAL,
  parameter int SYNC      = DEF_H_SYNC,
  parameter int ACT_START = H_ACT_START,
  parameter int ACT_LEN   = DEF_H_ACTIVE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  output logic               sync,
  output logic               active,
  output logic               wrap,
  output logic               nxt_act,
  output logic [COORD_W-1:0] pos
);

  localparam logic [COORD_W-1:0] LAST =
    COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] A_LO =
    COORD_W'(ACT_START);
  localparam logic [COORD_W-1:0] A_HI =
    COORD_W'(ACT_START + ACT_LEN);

  logic [COORD_W-1:0] cnt;
  logic [COORD_W-1:0] nxt;

  assign wrap    = (cnt == LAST);
  assign nxt     = wrap ? '0 : cnt + 1'b1;
  assign nxt_act = (nxt >= A_LO) && (nxt < A_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= LAST;
      sync   <= 1'b0;
      active <= 1'b0;
      pos    <= '0;
    end else if (inc) begin
      cnt    <= nxt;
      sync   <= nxt < COORD_W'(SYNC);
      active <= nxt_act;
      pos    <= nxt_act ? nxt - A_LO : '0;
    end
  end

endmodule

// File: rtl/dvi_timing_ctrl.sv
// TMDS sequencer in the x5 domain: pixel strobe, sync/DE
// timing, pixel prefetch via pix_req/pix_valid, underflow.
module dvi_timing_ctrl
  import dvi_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int SER_RATIO = DEF_SER
) (
  input  logic               clk_x5,
  input  logic               resetn,
  input  logic               enable,
  input  logic               clr_err,
  input  logic               pix_valid,
  input  logic [PIX_W-1:0]   pix_in,
  output logic               pix_stb,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [PIX_W-1:0]   pix_out,
  output logic               pix_req,
  output logic               frame_start,
  output logic               active_en,
  output logic               underflow
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PH_W = $clog2(SER_RATIO);
  localparam logic [PH_W-1:0] PH_LAST =
    PH_W'(SER_RATIO - 1);

  logic [PH_W-1:0] phase;
  logic            stb;
  logic            h_sync, h_act, h_wrap, h_nact;
  logic            v_sync, v_act, v_wrap, v_nact;
  logic [COORD_W-1:0] h_pos, v_pos;
  logic            pend, win, full, uf_set, next_act;
  logic [PIX_W-1:0] hold;

  assign stb     = (phase == PH_LAST);
  assign pix_stb = stb;

  always_ff @(posedge clk_x5 or negedge resetn) begin
    if (!resetn) phase <= '0;
    else         phase <= stb ? '0 : phase + 1'b1;
  end

  video_axis_counter #(
    .TOTAL(HT), .SYNC(H_SYNC),
    .ACT_START(H_SYNC + H_BP), .ACT_LEN(H_ACTIVE)
  ) u_h (
    .clk(clk_x5), .rst_n(resetn), .inc(stb),
    .sync(h_sync), .active(h_act), .wrap(h_wrap),
    .nxt_act(h_nact), .pos(h_pos)
  );

  video_axis_counter #(
    .TOTAL(VT), .SYNC(V_SYNC),
    .ACT_START(V_SYNC + V_BP), .ACT_LEN(V_ACTIVE)
  ) u_v (
    .clk(clk_x5), .rst_n(resetn), .inc(stb & h_wrap),
    .sync(v_sync), .active(v_act), .wrap(v_wrap),
    .nxt_act(v_nact), .pos(v_pos)
  );

  assign hsync = h_sync;
  assign vsync = v_sync;
  assign de    = active_en & h_act & v_act;
  assign x     = de ? h_pos : '0;
  assign y     = de ? v_pos : '0;

  // the line advances only when h wraps
  assign next_act = h_nact & (h_wrap ? v_nact : v_act);
  assign pix_req  = (phase == '0) & active_en & next_act;
  assign win      = pix_req | pend;
  assign uf_set   = stb & pend & ~full & ~pix_valid;

  always_ff @(posedge clk_x5 or negedge resetn) begin
    if (!resetn) begin
      frame_start <= 1'b0;
      active_en   <= 1'b0;
    end else if (stb) begin
      frame_start <= h_wrap & v_wrap;
      if (h_wrap & v_wrap) active_en <= enable;
    end
  end

  always_ff @(posedge clk_x5 or negedge resetn) begin
    if (!resetn) begin
      pend    <= 1'b0;
      full    <= 1'b0;
      hold    <= '0;
      pix_out <= '0;
    end else if (stb) begin
      pend <= 1'b0;
      full <= 1'b0;
      if (!pend)     pix_out <= '0;
      else if (full) pix_out <= hold;
      else if (pix_valid) pix_out <= pix_in;
      else           pix_out <= '0;
    end else begin
      if (pix_req) pend <= 1'b1;
      if (win && pix_valid && !full) begin
        hold <= pix_in;
        full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_x5 or negedge resetn) begin
    if (!resetn) underflow <= 1'b0;
    else underflow <= uf_set | (underflow & ~clr_err);
  end

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Randomized bench for dvi_timing_ctrl on a reduced raster
// against a position-arithmetic reference model.
module tb_dvi_timing_ctrl;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 2;
  localparam int SR = 5;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic clk_x5 = 1'b0;
  logic resetn = 1'b0;
  logic enable = 1'b0;
  logic clr_err = 1'b0;
  logic pix_valid = 1'b0;
  logic [23:0] pix_in = '0;
  logic pix_stb, hsync, vsync, de, pix_req;
  logic frame_start, active_en, underflow;
  logic [10:0] x, y;
  logic [23:0] pix_out;

  always #5 clk_x5 = ~clk_x5;

  dvi_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SER_RATIO(SR)
  ) dut (
    .clk_x5(clk_x5), .resetn(resetn), .enable(enable),
    .clr_err(clr_err), .pix_valid(pix_valid),
    .pix_in(pix_in), .pix_stb(pix_stb), .hsync(hsync),
    .vsync(vsync), .de(de), .x(x), .y(y),
    .pix_out(pix_out), .pix_req(pix_req),
    .frame_start(frame_start), .active_en(active_en),
    .underflow(underflow)
  );

  int vecs = 0;
  int errs = 0;

  // model state: n = clk edges since reset release
  int n, hc, vc;
  bit m_en, m_uf, m_de, exp_req;
  logic [23:0] m_pix;
  bit req_open, got;
  logic [23:0] got_data, send_data;
  logic [SR-1:0] plan;
  int last_fs, since_rel;
  bit did_rst, fs_prev;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s n=%0d got=%0h exp=%0h",
               nm, n, act, exp);
    end
  endtask

  function automatic bit act_at(input int h, input int v);
    return h >= HS + HB && h < HS + HB + HA &&
           v >= VS + VB && v < VS + VB + VA;
  endfunction

  task automatic reset_model();
    n = 0; hc = HT - 1; vc = VT - 1;
    m_en = 0; m_uf = 0; m_de = 0; m_pix = '0;
    req_open = 0; got = 0;
    last_fs = -1; fs_prev = 0; since_rel = 0;
  endtask

  task automatic chk_zero();
    chk("rst_stb", pix_stb, 0);
    chk("rst_hs", hsync, 0);
    chk("rst_vs", vsync, 0);
    chk("rst_de", de, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_pix", pix_out, 0);
    chk("rst_req", pix_req, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_aen", active_en, 0);
    chk("rst_uf", underflow, 0);
  endtask

  task automatic compare();
    int k;
    k = n / SR;
    exp_req = (n % SR == 0) && m_en &&
              act_at(k % HT, (k / HT) % VT);
    chk("pix_stb", pix_stb, (n % SR) == SR - 1);
    chk("hsync", hsync, hc < HS);
    chk("vsync", vsync, vc < VS);
    chk("frame_start", frame_start, hc == 0 && vc == 0);
    chk("active_en", active_en, m_en);
    chk("de", de, m_de);
    chk("x", x, m_de ? hc - HS - HB : 0);
    chk("y", y, m_de ? vc - VS - VB : 0);
    chk("pix_out", pix_out, m_pix);
    chk("pix_req", pix_req, exp_req);
    chk("underflow", underflow, m_uf);
  endtask

  // hand-derived anchors for the reduced raster
  task automatic literals();
    if (n == 3) chk("lit_stb3", pix_stb, 0);
    if (n == 4) chk("lit_stb4", pix_stb, 1);
    if (n == 5) begin
      chk("lit_fs5", frame_start, 1);
      chk("lit_hs5", hsync, 1);
      chk("lit_vs5", vsync, 1);
    end
    // (4 lines * 15 + 5) + 1 pixel edges, 5 clks each
    if (n == 329) chk("lit_de329", de, 0);
    if (n == 330) chk("lit_de330", de, 1);
    if (frame_start && !fs_prev) begin
      if (last_fs >= 0)
        chk("lit_frame_period", n - last_fs, 675);
      last_fs = n;
    end
    fs_prev = frame_start;
  endtask

  task automatic drive();
    int ph, k, l;
    ph = n % SR;
    k = n / SR;
    if (exp_req) begin
      req_open = 1;
      got = 0;
      if ($urandom_range(15) == 0) plan = '0;
      else begin
        l = $urandom_range(SR - 1);
        plan = '0;
        plan[l] = 1'b1;
        if (l < SR - 1 && $urandom_range(3) == 0)
          plan[$urandom_range(SR - 1, l + 1)] = 1'b1;
      end
      send_data = {2'b00,
                   11'(k % HT - HS - HB),
                   11'((k / HT) % VT - VS - VB)};
    end
    if (req_open) begin
      pix_valid = plan[ph];
      if (plan[ph]) begin
        pix_in = got ? ~send_data : send_data;
        if (!got) begin
          got = 1;
          got_data = send_data;
        end
      end else pix_in = 24'($urandom);
    end else begin
      pix_valid = ($urandom_range(7) == 0);
      pix_in = 24'($urandom);
    end
    clr_err = ($urandom_range(99) == 0);
    if (since_rel > 500 && $urandom_range(999) == 0)
      enable = ~enable;
  endtask

  task automatic update();
    int p;
    bit set;
    set = 0;
    n++;
    since_rel++;
    if (n % SR == 0) begin
      p = n / SR - 1;
      hc = p % HT;
      vc = (p / HT) % VT;
      if (hc == 0 && vc == 0) m_en = enable;
      if (req_open) begin
        m_pix = got ? got_data : '0;
        set = !got;
      end else m_pix = '0;
      m_de = m_en && act_at(hc, vc);
      req_open = 0;
      got = 0;
    end
    if (set) m_uf = 1;
    else if (clr_err) m_uf = 0;
  endtask

  initial begin
    enable = 1;
    did_rst = 0;
    repeat (3) @(negedge clk_x5);
    chk_zero();
    resetn = 1;
    reset_model();
    for (int c = 0; c < 9000; c++) begin
      compare();
      literals();
      if (!did_rst && c > 4000 && hc == 7 &&
          n % SR == 2) begin
        did_rst = 1;
        #2 resetn = 0;
        #1 chk_zero();
        pix_valid = 0;
        clr_err = 0;
        enable = 1;
        @(posedge clk_x5);
        @(negedge clk_x5);
        chk_zero();
        resetn = 1;
        reset_model();
        continue;
      end
      drive();
      @(posedge clk_x5);
      update();
      @(negedge clk_x5);
    end
    if (!did_rst) chk("mid_reset_hit", 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
